// File: rtl/rmii_frame_tx.sv
// Ethernet II framer on RMII TX: preamble/SFD, fixed header, payload from a dibit stream,
// zero padding to minimum length, CRC-32 FCS and inter-packet gap.
module rmii_frame_tx #(
  parameter logic [47:0] DST_MAC           = 48'hFF_FF_FF_FF_FF_FF,
  parameter logic [47:0] SRC_MAC           = 48'h02_00_00_00_00_01,
  parameter logic [15:0] ETHERTYPE         = 16'h88B5,
  parameter int unsigned MIN_PAYLOAD_BYTES = 46,
  parameter int unsigned MAX_PAYLOAD_BYTES = 1500,
  parameter int unsigned IPG_DIBITS        = 48
) (
  input  logic       eth_refclk,
  input  logic       rst_n,
  input  logic [1:0] in_dibit,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [1:0] eth_txd,
  output logic       eth_txen,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int unsigned CNT_W = 13;

  localparam logic [CNT_W-1:0] PRE_LAST   = CNT_W'(31);
  localparam logic [CNT_W-1:0] HDR_LAST   = CNT_W'(55);
  localparam logic [CNT_W-1:0] FCS_LAST   = CNT_W'(15);
  localparam logic [CNT_W-1:0] MIN_DIBITS = CNT_W'(4 * MIN_PAYLOAD_BYTES);
  localparam logic [CNT_W-1:0] MAX_DIBITS = CNT_W'(4 * MAX_PAYLOAD_BYTES);
  localparam logic [CNT_W-1:0] IPG_LAST   = CNT_W'(IPG_DIBITS - 1);

  localparam logic [31:0]  CRC_POLY = 32'hEDB88320;
  localparam logic [31:0]  CRC_INIT = 32'hFFFFFFFF;
  localparam logic [111:0] HDR      = {DST_MAC, SRC_MAC, ETHERTYPE};

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PREAMBLE = 3'd1;
  localparam logic [2:0] S_HEADER   = 3'd2;
  localparam logic [2:0] S_PAYLOAD  = 3'd3;
  localparam logic [2:0] S_PAD      = 3'd4;
  localparam logic [2:0] S_FCS      = 3'd5;
  localparam logic [2:0] S_IPG      = 3'd6;

  logic [2:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic [CNT_W-1:0] pad_len, pad_nxt, pay_rnd, pay_tgt;
  logic [31:0]      crc, crc_nxt, fcs_word;
  logic [1:0]       txd_nxt, hdr_dibit, fcs_dibit;
  logic             txen_nxt, done_nxt, err_nxt;
  logic [6:0]       hdr_sh;
  logic [7:0]       hdr_byte;

  // Reflected CRC-32 advanced by one dibit, bit 0 first
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 2; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ CRC_POLY;
      else             r = r >> 1;
    end
    return r;
  endfunction

  assign cnt_inc   = cnt + CNT_W'(1);
  assign pay_rnd   = (cnt_inc + CNT_W'(3)) & ~CNT_W'(3);
  assign pay_tgt   = (cnt_inc < MIN_DIBITS) ? MIN_DIBITS : pay_rnd;
  assign hdr_sh    = 7'd104 - {cnt[5:2], 3'b000};
  assign hdr_byte  = 8'(HDR >> hdr_sh);
  assign hdr_dibit = 2'(hdr_byte >> {cnt[1:0], 1'b0});
  assign fcs_word  = ~crc;
  assign fcs_dibit = 2'(fcs_word >> {cnt[3:0], 1'b0});

  // Next state, counter, CRC and the line values to register for the next cycle
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_inc;
    pad_nxt   = pad_len;
    crc_nxt   = crc;
    txd_nxt   = 2'b00;
    txen_nxt  = 1'b0;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        if (in_valid) state_nxt = S_PREAMBLE;
      end
      S_PREAMBLE: begin
        txen_nxt = 1'b1;
        txd_nxt  = (cnt == PRE_LAST) ? 2'b11 : 2'b01;
        crc_nxt  = CRC_INIT;
        if (cnt == PRE_LAST) begin
          state_nxt = S_HEADER;
          cnt_nxt   = '0;
        end
      end
      S_HEADER: begin
        txen_nxt = 1'b1;
        txd_nxt  = hdr_dibit;
        crc_nxt  = crc_step(crc, hdr_dibit);
        if (cnt == HDR_LAST) begin
          state_nxt = S_PAYLOAD;
          cnt_nxt   = '0;
        end
      end
      S_PAYLOAD: begin
        if (!in_valid) begin
          err_nxt   = 1'b1;
          state_nxt = S_IPG;
          cnt_nxt   = '0;
        end else begin
          txen_nxt = 1'b1;
          txd_nxt  = in_dibit;
          crc_nxt  = crc_step(crc, in_dibit);
          if (in_last) begin
            // PAD also completes a partial final byte when the payload is long enough
            pad_nxt   = pay_tgt - cnt_inc;
            state_nxt = (pay_tgt == cnt_inc) ? S_FCS : S_PAD;
            cnt_nxt   = '0;
          end else if (cnt_inc == MAX_DIBITS) begin
            err_nxt   = 1'b1;
            state_nxt = S_FCS;
            cnt_nxt   = '0;
          end
        end
      end
      S_PAD: begin
        txen_nxt = 1'b1;
        crc_nxt  = crc_step(crc, 2'b00);
        if (cnt_inc == pad_len) begin
          state_nxt = S_FCS;
          cnt_nxt   = '0;
        end
      end
      S_FCS: begin
        txen_nxt = 1'b1;
        txd_nxt  = fcs_dibit;
        if (cnt == FCS_LAST) begin
          done_nxt  = 1'b1;
          state_nxt = S_IPG;
          cnt_nxt   = '0;
        end
      end
      S_IPG: begin
        if (cnt == IPG_LAST) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge eth_refclk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      pad_len  <= '0;
      crc      <= CRC_INIT;
      eth_txd  <= 2'b00;
      eth_txen <= 1'b0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
      tx_err   <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      pad_len  <= pad_nxt;
      crc      <= crc_nxt;
      eth_txd  <= txd_nxt;
      eth_txen <= txen_nxt;
      in_ready <= (state_nxt == S_PAYLOAD) && (cnt_nxt < MAX_DIBITS);
      busy     <= (state_nxt != S_IDLE);
      tx_done  <= done_nxt;
      tx_err   <= err_nxt;
    end
  end

endmodule
